// File: rtl/base_parity_scrub.sv
// Read-port controller for a parity-protected array with 1-cycle read latency:
// arbitrates functional reads against a background scrubber and logs parity errors.
module base_parity_scrub #(
  parameter int awidth   = 4,
  parameter int dwidth   = 64,
  parameter int pwidth   = 8,
  parameter int interval = 16,
  parameter int maxwait  = 8,
  parameter int cwidth   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_f_v,
  output logic              o_f_r,
  input  logic [awidth-1:0] i_f_a,
  output logic              o_f_v,
  output logic [dwidth-1:0] o_f_d,
  output logic              o_f_perr,
  output logic              o_rd_v,
  output logic [awidth-1:0] o_rd_a,
  input  logic [dwidth-1:0] i_rd_d,
  input  logic [pwidth-1:0] i_rd_p,
  input  logic              i_scrub_en,
  input  logic              i_err_clr,
  output logic              o_err_v,
  output logic              o_err_scrub,
  output logic [awidth-1:0] o_err_a,
  output logic              o_first_v,
  output logic [awidth-1:0] o_first_a,
  output logic [cwidth-1:0] o_err_cnt
);

  localparam int gw = dwidth / pwidth;
  localparam int iw = $clog2(interval);
  localparam int ww = (maxwait < 1) ? 1 : $clog2(maxwait + 1);

  function automatic logic [pwidth-1:0] calc_parity(input logic [dwidth-1:0] d);
    logic [pwidth-1:0] p;
    p = '0;
    for (int k = 0; k < pwidth; k++) begin
      p[k] = ^d[k*gw +: gw];
    end
    return p;
  endfunction

  logic [iw-1:0]     int_cnt_q, int_cnt_d;
  logic [ww-1:0]     wait_cnt_q, wait_cnt_d;
  logic [awidth-1:0] ptr_q, ptr_d;
  logic              pend_q, pend_d;
  logic              s1_v_q, s1_v_d;
  logic              s1_scrub_q, s1_scrub_d;
  logic [awidth-1:0] s1_a_q, s1_a_d;
  logic              f_v_q, f_v_d;
  logic [dwidth-1:0] f_d_q, f_d_d;
  logic              f_perr_q, f_perr_d;
  logic              err_v_q, err_v_d;
  logic              err_scrub_q, err_scrub_d;
  logic [awidth-1:0] err_a_q, err_a_d;
  logic              first_v_q, first_v_d;
  logic [awidth-1:0] first_a_q, first_a_d;
  logic [cwidth-1:0] err_cnt_q, err_cnt_d;
  logic              f_acc;
  logic              s_iss;
  logic              perr;

  // Read-port arbitration: a starved scrub blocks the functional port for one cycle.
  always_comb begin
    o_f_r  = !reset && !(pend_q && (wait_cnt_q == ww'(maxwait)));
    f_acc  = i_f_v && o_f_r;
    s_iss  = !reset && !f_acc && pend_q;
    o_rd_v = f_acc || s_iss;
    o_rd_a = f_acc ? i_f_a : ptr_q;
  end

  // Scrub scheduling; the interval keeps counting in the cycle the scrub issues.
  always_comb begin
    int_cnt_d  = int_cnt_q;
    wait_cnt_d = wait_cnt_q;
    pend_d     = pend_q;
    ptr_d      = ptr_q;
    if (s_iss) begin
      pend_d     = 1'b0;
      wait_cnt_d = '0;
      ptr_d      = ptr_q + awidth'(1);
    end else if (pend_q && f_acc && (wait_cnt_q != ww'(maxwait))) begin
      wait_cnt_d = wait_cnt_q + ww'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    if (!pend_q || s_iss) begin
      if (int_cnt_q == iw'(interval - 1)) begin
        int_cnt_d = '0;
        pend_d    = 1'b1;
      end else begin
        int_cnt_d = int_cnt_q + iw'(1);
      end
    end else begin
      int_cnt_d = int_cnt_q;
    end
    if (!i_scrub_en) begin
      int_cnt_d  = '0;
      pend_d     = 1'b0;
      wait_cnt_d = '0;
    end else begin
      pend_d = pend_d;
    end
  end

  // Parity check on returning data and next values of the response/error registers.
  always_comb begin
    perr        = s1_v_q && (calc_parity(i_rd_d) != i_rd_p);
    s1_v_d      = o_rd_v;
    s1_a_d      = o_rd_a;
    s1_scrub_d  = s_iss;
    f_v_d       = s1_v_q && !s1_scrub_q;
    f_d_d       = f_v_d ? i_rd_d : '0;
    f_perr_d    = f_v_d && perr;
    err_v_d     = perr;
    err_scrub_d = perr && s1_scrub_q;
    err_a_d     = perr ? s1_a_q : '0;
    err_cnt_d   = err_cnt_q;
    first_v_d   = first_v_q;
    first_a_d   = first_a_q;
    if (perr) begin
      if (i_err_clr) begin
        err_cnt_d = cwidth'(1);
      end else if (err_cnt_q != {cwidth{1'b1}}) begin
        err_cnt_d = err_cnt_q + cwidth'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
      if (!first_v_q || i_err_clr) begin
        first_v_d = 1'b1;
        first_a_d = s1_a_q;
      end else begin
        first_a_d = first_a_q;
      end
    end else if (i_err_clr) begin
      err_cnt_d = '0;
      first_v_d = 1'b0;
      first_a_d = '0;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      ptr_q       <= '0;
      pend_q      <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_scrub_q  <= 1'b0;
      s1_a_q      <= '0;
      f_v_q       <= 1'b0;
      f_d_q       <= '0;
      f_perr_q    <= 1'b0;
      err_v_q     <= 1'b0;
      err_scrub_q <= 1'b0;
      err_a_q     <= '0;
      first_v_q   <= 1'b0;
      first_a_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      int_cnt_q   <= int_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      s1_v_q      <= s1_v_d;
      s1_scrub_q  <= s1_scrub_d;
      s1_a_q      <= s1_a_d;
      f_v_q       <= f_v_d;
      f_d_q       <= f_d_d;
      f_perr_q    <= f_perr_d;
      err_v_q     <= err_v_d;
      err_scrub_q <= err_scrub_d;
      err_a_q     <= err_a_d;
      first_v_q   <= first_v_d;
      first_a_q   <= first_a_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_f_v       = f_v_q;
  assign o_f_d       = f_d_q;
  assign o_f_perr    = f_perr_q;
  assign o_err_v     = err_v_q;
  assign o_err_scrub = err_scrub_q;
  assign o_err_a     = err_a_q;
  assign o_first_v   = first_v_q;
  assign o_first_a   = first_a_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_base_parity_scrub.sv
// Directed bench for base_parity_scrub: a cycle model of the read port and error
// log is compared every cycle, plus hand-computed checks per scenario.
module tb_base_parity_scrub;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int PW = 8;
  localparam int INTERVAL = 16;
  localparam int MAXWAIT = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_f_v = 1'b0;
  logic          o_f_r;
  logic [AW-1:0] i_f_a = '0;
  logic          o_f_v;
  logic [DW-1:0] o_f_d;
  logic          o_f_perr;
  logic          o_rd_v;
  logic [AW-1:0] o_rd_a;
  logic [DW-1:0] i_rd_d;
  logic [PW-1:0] i_rd_p;
  logic          i_scrub_en = 1'b0;
  logic          i_err_clr = 1'b0;
  logic          o_err_v;
  logic          o_err_scrub;
  logic [AW-1:0] o_err_a;
  logic          o_first_v;
  logic [AW-1:0] o_first_a;
  logic [CW-1:0] o_err_cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [16];
  logic [PW-1:0] par [16];
  logic [AW-1:0] rd_a_lat = '0;

  base_parity_scrub #(.awidth(AW), .dwidth(DW), .pwidth(PW), .interval(INTERVAL),
                      .maxwait(MAXWAIT), .cwidth(CW)) dut (
    .clk(clk), .reset(reset), .i_f_v(i_f_v), .o_f_r(o_f_r), .i_f_a(i_f_a),
    .o_f_v(o_f_v), .o_f_d(o_f_d), .o_f_perr(o_f_perr), .o_rd_v(o_rd_v),
    .o_rd_a(o_rd_a), .i_rd_d(i_rd_d), .i_rd_p(i_rd_p), .i_scrub_en(i_scrub_en),
    .i_err_clr(i_err_clr), .o_err_v(o_err_v), .o_err_scrub(o_err_scrub),
    .o_err_a(o_err_a), .o_first_v(o_first_v), .o_first_a(o_first_a),
    .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  // External array: data appears the cycle after the read is issued.
  always @(posedge clk) rd_a_lat <= o_rd_a;
  assign i_rd_d = mem[rd_a_lat];
  assign i_rd_p = par[rd_a_lat];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] even_par(input logic [DW-1:0] d);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < PW; k++) p[k] = ^d[k*(DW/PW) +: DW/PW];
    return p;
  endfunction

  // Model state: scrub schedule, one read in flight, expected registered outputs.
  int            m_cnt = 0;
  int            m_wait = 0;
  logic          m_pend = 1'b0;
  logic [AW-1:0] m_ptr = '0;
  logic          p1_v = 1'b0;
  logic          p1_s = 1'b0;
  logic [AW-1:0] p1_a = '0;
  logic          e_f_v = 1'b0;
  logic [DW-1:0] e_f_d = '0;
  logic          e_f_perr = 1'b0;
  logic          e_err_v = 1'b0;
  logic          e_err_s = 1'b0;
  logic [AW-1:0] e_err_a = '0;
  logic          e_first_v = 1'b0;
  logic [AW-1:0] e_first_a = '0;
  int            e_cnt = 0;

  always @(negedge clk) begin
    logic fr, facc, sacc, rdv, bad;
    logic [AW-1:0] rda;
    fr   = !reset && !(m_pend && m_wait == MAXWAIT);
    facc = i_f_v && fr;
    sacc = !reset && !facc && m_pend;
    rdv  = facc || sacc;
    rda  = facc ? i_f_a : m_ptr;
    chk("m_f_r", o_f_r, fr);
    chk("m_rd_v", o_rd_v, rdv);
    if (rdv) chk("m_rd_a", o_rd_a, rda);
    chk("m_f_v", o_f_v, e_f_v);
    if (e_f_v) begin
      chk("m_f_d", o_f_d, e_f_d);
      chk("m_f_perr", o_f_perr, e_f_perr);
    end
    chk("m_err_v", o_err_v, e_err_v);
    if (e_err_v) begin
      chk("m_err_a", o_err_a, e_err_a);
      chk("m_err_scrub", o_err_scrub, e_err_s);
    end
    chk("m_first_v", o_first_v, e_first_v);
    chk("m_first_a", o_first_a, e_first_a);
    chk("m_err_cnt", o_err_cnt, e_cnt);
    if (reset) begin
      m_cnt = 0; m_wait = 0; m_pend = 1'b0; m_ptr = '0;
      p1_v = 1'b0; p1_s = 1'b0; p1_a = '0;
      e_f_v = 1'b0; e_f_d = '0; e_f_perr = 1'b0; e_err_v = 1'b0; e_err_s = 1'b0;
      e_err_a = '0; e_first_v = 1'b0; e_first_a = '0; e_cnt = 0;
    end else begin
      bad      = p1_v && (even_par(mem[p1_a]) != par[p1_a]);
      e_f_v    = p1_v && !p1_s;
      e_f_d    = mem[p1_a];
      e_f_perr = bad;
      e_err_v  = bad;
      e_err_s  = p1_s;
      e_err_a  = p1_a;
      if (bad) begin
        e_cnt = i_err_clr ? 1 : ((e_cnt == (1 << CW) - 1) ? e_cnt : e_cnt + 1);
        if (!e_first_v || i_err_clr) begin
          e_first_v = 1'b1;
          e_first_a = p1_a;
        end
      end else if (i_err_clr) begin
        e_cnt = 0; e_first_v = 1'b0; e_first_a = '0;
      end
      p1_v = rdv; p1_s = sacc; p1_a = rda;
      if (sacc) m_ptr = m_ptr + 4'd1;
      if (!i_scrub_en) begin
        m_cnt = 0; m_pend = 1'b0; m_wait = 0;
      end else if (sacc) begin
        m_pend = 1'b0; m_wait = 0; m_cnt = m_cnt + 1;
      end else if (m_pend) begin
        if (facc && m_wait < MAXWAIT) m_wait = m_wait + 1;
      end else if (m_cnt == INTERVAL - 1) begin
        m_cnt = 0; m_pend = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one functional read this cycle and stop at the middle of its response cycle.
  task automatic fread(input logic [AW-1:0] a);
    i_f_v = 1'b1;
    i_f_a = a;
    cyc();
    i_f_v = 1'b0;
    cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, drops;
    logic found;
    for (int i = 0; i < 16; i++) begin
      mem[i] = {16{4'(i)}};
      par[i] = 8'h00;
    end
    par[9] = 8'h10;
    mem[5] = 64'h0123456789ABCDEF;
    par[5] = 8'hFF;

    repeat (3) cyc();
    @(negedge clk);
    chk("reset_f_r", o_f_r, 1'b0);
    chk("reset_rd_v", o_rd_v, 1'b0);
    chk("reset_f_v", o_f_v, 1'b0);
    chk("reset_err_cnt", o_err_cnt, 2'd0);
    chk("reset_first_v", o_first_v, 1'b0);
    cyc();
    reset = 1'b0;

    // Scrub only: one read every 16 cycles, addresses 0..15 then 0.
    cyc();
    i_scrub_en = 1'b1;
    n = 0;
    for (int c = 0; c < 274; c++) begin
      @(negedge clk);
      if (o_rd_v) begin
        if (n < 17) begin
          chk("scrub_cycle", 64'(c), 64'(16 * (n + 1)));
          chk("scrub_addr", o_rd_a, 64'(n % 16));
        end
        n++;
      end
      cyc();
    end
    chk("scrub_count", 64'(n), 64'd17);
    i_scrub_en = 1'b0;
    par[9] = 8'h00;
    cyc();
    i_err_clr = 1'b1;
    cyc();
    i_err_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt", o_err_cnt, 2'd0);
    chk("clr_first_v", o_first_v, 1'b0);

    // Clean functional read.
    cyc();
    fread(4'd5);
    chk("good_f_v", o_f_v, 1'b1);
    chk("good_f_d", o_f_d, 64'h0123456789ABCDEF);
    chk("good_perr", o_f_perr, 1'b0);
    chk("good_err_v", o_err_v, 1'b0);

    // Parity errors at 3 then 7.
    mem[3] = 64'h0123456789ABCDEF;
    par[3] = 8'hFE;
    par[7] = 8'h01;
    cyc();
    fread(4'd3);
    chk("err1_perr", o_f_perr, 1'b1);
    chk("err1_err_v", o_err_v, 1'b1);
    chk("err1_err_a", o_err_a, 4'd3);
    chk("err1_scrub", o_err_scrub, 1'b0);
    chk("err1_first_a", o_first_a, 4'd3);
    chk("err1_cnt", o_err_cnt, 2'd1);
    cyc();
    fread(4'd7);
    chk("err2_err_a", o_err_a, 4'd7);
    chk("err2_first_a", o_first_a, 4'd3);
    chk("err2_cnt", o_err_cnt, 2'd2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      fread(4'd3);
    end
    chk("sat_cnt", o_err_cnt, 2'd3);

    // Clear in the same cycle as an error: the error wins.
    cyc();
    i_f_v = 1'b1;
    i_f_a = 4'd7;
    cyc();
    i_f_v = 1'b0;
    i_err_clr = 1'b1;
    cyc();
    i_err_clr = 1'b0;
    @(negedge clk);
    chk("clrerr_cnt", o_err_cnt, 2'd1);
    chk("clrerr_first_v", o_first_v, 1'b1);
    chk("clrerr_first_a", o_first_a, 4'd7);

    // Starvation: functional traffic every cycle; scrub forced through at wait 8.
    cyc();
    i_scrub_en = 1'b1;
    i_f_v = 1'b1;
    drops = 0;
    for (int c = 0; c < 30; c++) begin
      i_f_a = 4'(c);
      @(negedge clk);
      if (!o_f_r) begin
        drops++;
        chk("starve_cycle", 64'(c), 64'd24);
        chk("starve_rd_a", o_rd_a, 4'd1);
        chk("starve_rd_v", o_rd_v, 1'b1);
      end
      if (c == 25) chk("starve_ready_back", o_f_r, 1'b1);
      cyc();
    end
    chk("starve_drops", 64'(drops), 64'd1);
    i_f_v = 1'b0;
    i_scrub_en = 1'b0;

    // Reset one cycle after a functional issue.
    cyc();
    i_f_v = 1'b1;
    i_f_a = 4'd3;
    cyc();
    i_f_v = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_f_v", o_f_v, 1'b0);
    chk("rst_f_d", o_f_d, 64'h0);
    chk("rst_err_v", o_err_v, 1'b0);
    chk("rst_cnt", o_err_cnt, 2'd0);
    chk("rst_first_v", o_first_v, 1'b0);
    cyc();
    i_scrub_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_rd_v && !found) begin
        found = 1'b1;
        chk("rst_scrub_addr", o_rd_a, 4'd0);
      end
      cyc();
    end
    chk("rst_scrub_seen", found, 1'b1);
    i_scrub_en = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
